// File: rtl/reg_pipe_pkg.sv
// Shared helpers for the register pipeline: count width and default data reset value.
package reg_pipe_pkg;

  localparam logic [63:0] RESET_VALUE_DEF = '0;

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/dffre_vec.sv
// WIDTH-bit flop with enable; sync reset only when REG_PIPE_DATA_RESET_EN is defined.
// One-cycle latency when enabled; holds when en=0.
module dffre_vec #(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

`ifdef REG_PIPE_DATA_RESET_EN
  always_ff @(posedge clk) begin
    if (rst)     q <= RST_VAL;
    else if (en) q <= d;
  end
`else
  // Data path carries no reset; consumers qualify data with the valid bit.
  logic [WIDTH:0] unused_rst;
  assign unused_rst = {rst, RST_VAL};

  always_ff @(posedge clk) begin
    if (en) q <= d;
  end
`endif

endmodule

// File: rtl/reg_pipe_rte.sv
// DEPTH-stage valid/data delay line with shared stall, sync flush and live valid count.
// Latency DEPTH enabled edges; en=0 freezes everything. Data reset via REG_PIPE_DATA_RESET_EN.
module reg_pipe_rte
  import reg_pipe_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter int               DEPTH       = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE = RESET_VALUE_DEF[WIDTH-1:0]
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         flush,
  input  logic                         in_val,
  input  logic [WIDTH-1:0]             in_data,
  output logic                         out_val,
  output logic [WIDTH-1:0]             out_data,
  output logic [cnt_width(DEPTH)-1:0]  count
);

  localparam int CW = cnt_width(DEPTH);

  logic [DEPTH-1:0] val_q, val_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] dat_q [DEPTH];
  logic [WIDTH-1:0] dat_d [DEPTH];
  logic             dat_en;

  always_comb begin
    val_d    = '0;
    val_d[0] = in_val;
    for (int i = 1; i < DEPTH; i++) val_d[i] = val_q[i-1];
  end

  // Incremental count: enter and exit in the same cycle cancel out.
  always_comb begin
    count_d = count_q + CW'(in_val) - CW'(val_q[DEPTH-1]);
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      val_q   <= '0;
      count_q <= '0;
    end else if (en) begin
      val_q   <= val_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    dat_d[0] = in_data;
    for (int i = 1; i < DEPTH; i++) dat_d[i] = dat_q[i-1];
  end

  // Flush leaves data untouched; only the valid bits are cleared.
  assign dat_en = en & ~flush;

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    dffre_vec #(
      .WIDTH   (WIDTH),
      .RST_VAL (RESET_VALUE)
    ) u_stage (
      .clk (clk),
      .rst (rst),
      .en  (dat_en),
      .d   (dat_d[g]),
      .q   (dat_q[g])
    );
  end

  assign out_val  = val_q[DEPTH-1];
  assign out_data = dat_q[DEPTH-1];
  assign count    = count_q;

endmodule

// File: tb/tb_reg_pipe_rte.sv
// Scoreboard bench for reg_pipe_rte: DEPTH=4 main instance plus a DEPTH=1 instance.
module tb_reg_pipe_rte;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0, en = 1'b0, flush = 1'b0, in_val = 1'b0;
  logic [7:0] in_data = '0;
  logic       out_val;
  logic [7:0] out_data;
  logic [2:0] count;

  logic       d1_rst = 1'b0, d1_en = 1'b0, d1_val = 1'b0;
  logic [7:0] d1_dat = '0;
  logic       d1_out_val;
  logic [7:0] d1_out_data;
  logic       d1_count;

  int checks = 0;
  int errors = 0;
  int adv    = 0;

  typedef struct {
    int         due;
    logic [7:0] dat;
  } sb_t;
  sb_t sb[$];

  always #5 clk = ~clk;

  reg_pipe_rte #(.WIDTH(8), .DEPTH(DEPTH)) u_dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .flush    (flush),
    .in_val   (in_val),
    .in_data  (in_data),
    .out_val  (out_val),
    .out_data (out_data),
    .count    (count)
  );

  reg_pipe_rte #(.WIDTH(8), .DEPTH(1)) u_dut1 (
    .clk      (clk),
    .rst      (d1_rst),
    .en       (d1_en),
    .flush    (1'b0),
    .in_val   (d1_val),
    .in_data  (d1_dat),
    .out_val  (d1_out_val),
    .out_data (d1_out_data),
    .count    (d1_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one cycle, update the scoreboard at the edge, then compare 1 time unit later.
  task automatic step(input logic r, input logic f, input logic e, input logic v,
                      input logic [7:0] d);
    sb_t  ent;
    logic exp_v;
    rst = r; flush = f; en = e; in_val = v; in_data = d;
    @(posedge clk);
    if (r || f) begin
      sb.delete();
    end else if (e) begin
      adv++;
      if (v) begin
        ent.due = adv + DEPTH - 1;
        ent.dat = d;
        sb.push_back(ent);
      end
    end
    while (sb.size() > 0 && sb[0].due < adv) void'(sb.pop_front());
    #1;
    exp_v = (sb.size() > 0) && (sb[0].due == adv);
    chk("out_val", 32'(out_val), 32'(exp_v));
    chk("count", 32'(count), 32'(sb.size()));
    if (exp_v) chk("out_data", 32'(out_data), 32'(sb[0].dat));
  endtask

  initial begin
    // Reset, two cycles
    step(1, 0, 0, 0, 8'h00);
    step(1, 0, 1, 1, 8'h99);
`ifdef REG_PIPE_DATA_RESET_EN
    chk("rst_data", 32'(out_data), 32'h00);
`endif

    // Streaming with a mid-stream 3-cycle stall
    step(0, 0, 1, 1, 8'h11);
    step(0, 0, 1, 1, 8'h22);
    step(0, 0, 1, 1, 8'h33);
    step(0, 0, 1, 1, 8'h44);
    chk("first_out", 32'(out_data), 32'h11);
    step(0, 0, 1, 1, 8'h55);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 8'hEE);
    step(0, 0, 1, 1, 8'h66);
    step(0, 0, 1, 1, 8'h77);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 8'h00);

    // Bubbles 1,0,1,1 then one more so a sample enters while one exits
    step(0, 0, 1, 1, 8'hA1);
    step(0, 0, 1, 0, 8'h00);
    step(0, 0, 1, 1, 8'hA3);
    step(0, 0, 1, 1, 8'hA4);
    chk("bubble_cnt3", 32'(count), 32'd3);
    step(0, 0, 1, 1, 8'hA5);
    chk("enter_exit_cnt", 32'(count), 32'd3);

    // Flush with en=1 and in_val=1: flushed input must never emerge
    step(0, 1, 1, 1, 8'hF1);
    chk("flush_cnt", 32'(count), 32'd0);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 8'h00);

    // Reset beats flush and en mid-stream
    step(0, 0, 1, 1, 8'hB1);
    step(0, 0, 1, 1, 8'hB2);
    step(1, 1, 1, 1, 8'hB3);
    chk("rst_prio_val", 32'(out_val), 32'd0);
`ifdef REG_PIPE_DATA_RESET_EN
    chk("rst_prio_data", 32'(out_data), 32'h00);
`endif
    step(0, 0, 1, 1, 8'hC1);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 8'h00);

    // DEPTH=1 instance
    d1_rst = 1'b1; d1_en = 1'b1; d1_val = 1'b0;
    @(posedge clk); #1;
    chk("d1_rst_val", 32'(d1_out_val), 32'd0);
    chk("d1_rst_cnt", 32'(d1_count), 32'd0);
    d1_rst = 1'b0; d1_val = 1'b1; d1_dat = 8'hA5;
    @(posedge clk); #1;
    chk("d1_val", 32'(d1_out_val), 32'd1);
    chk("d1_data", 32'(d1_out_data), 32'hA5);
    chk("d1_cnt", 32'(d1_count), 32'd1);
    d1_en = 1'b0; d1_val = 1'b0;
    @(posedge clk); #1;
    chk("d1_stall_val", 32'(d1_out_val), 32'd1);
    d1_en = 1'b1;
    @(posedge clk); #1;
    chk("d1_drain_val", 32'(d1_out_val), 32'd0);
    chk("d1_drain_cnt", 32'(d1_count), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
